// File: rtl/batcher_pkg.sv
// batcher_pkg: state and conflict-type enums, descriptor count width and saturating
// statistics helper shared by batch_former and its interface.
package batcher_pkg;
    localparam int STAT_W = 32;
    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} bf_state_e;
    typedef enum logic [1:0] {CONF_RAW, CONF_WAW, CONF_WAR} conflict_e;
    function automatic int count_w(input int max_batch);
        return $clog2(max_batch + 1);
    endfunction
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return v + STAT_W'(en && !(&v));
    endfunction
endpackage

// File: rtl/batch_former_if.sv
// batch_former_if: per-channel transaction ingress, batch descriptor egress and statistics.
interface batch_former_if import batcher_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int DEP_W = 256,
    parameter int MAX_BATCH_SIZE = 8
);
    logic [NUM_CH-1:0] s_tvalid, s_tready;
    logic [64*NUM_CH-1:0] s_owner_id;
    logic [DEP_W*NUM_CH-1:0] s_rd_deps, s_wr_deps;
    logic m_tvalid, m_tready;
    logic [count_w(MAX_BATCH_SIZE)-1:0] m_count;
    logic [63:0] m_owner_id;
    logic [DEP_W-1:0] m_rd_union, m_wr_union;
    logic [STAT_W-1:0] raw_conflicts, waw_conflicts, war_conflicts, batches_emitted;
    modport master (
        output s_tvalid, s_owner_id, s_rd_deps, s_wr_deps, m_tready,
        input s_tready, m_tvalid, m_count, m_owner_id, m_rd_union, m_wr_union,
        input raw_conflicts, waw_conflicts, war_conflicts, batches_emitted
    );
    modport slave (
        input s_tvalid, s_owner_id, s_rd_deps, s_wr_deps, m_tready,
        output s_tready, m_tvalid, m_count, m_owner_id, m_rd_union, m_wr_union,
        output raw_conflicts, waw_conflicts, war_conflicts, batches_emitted
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; the priority pointer moves past the winner only when advanced.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic [N-1:0] req,
    input  logic advance,
    output logic [N-1:0] grant,
    output logic [IW-1:0] grant_idx
);
    logic [IW-1:0] ptr;
    always_comb begin
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) grant_idx = IW'((int'(ptr) + k) % N);
        grant = '0;
        grant[grant_idx] = |req;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= '0;
        else if (advance) ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/batch_former.sv
// batch_former: packs non-conflicting transactions from NUM_CH channels into batch descriptors.
// Define BATCH_FORMER_STATS_EN to build the conflict and batch statistics counters.
module batch_former import batcher_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int DEP_W = 256,
    parameter int MAX_BATCH_SIZE = 8,
    parameter int BATCH_TIMEOUT_CYCLES = 100
) (
    input logic clk,
    input logic rst,
    batch_former_if.slave bus
);
    localparam int CW = count_w(MAX_BATCH_SIZE);
    localparam int TW = count_w(BATCH_TIMEOUT_CYCLES);
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    bf_state_e state, state_nx;
    logic [CW-1:0] count;
    logic [TW-1:0] timer;
    logic [63:0] owner;
    logic [DEP_W-1:0] rd_union, wr_union, cand_rd, cand_wr;
    logic [NUM_CH-1:0] grant;
    logic [IW-1:0] gidx;
    logic has_req, raw, waw, war, conflict, timeout, accept, full;
    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk(clk), .rst(rst), .req(bus.s_tvalid), .advance(accept), .grant(grant), .grant_idx(gidx)
    );
    assign has_req = |bus.s_tvalid;
    assign cand_rd = bus.s_rd_deps[int'(gidx)*DEP_W +: DEP_W];
    assign cand_wr = bus.s_wr_deps[int'(gidx)*DEP_W +: DEP_W];
    assign raw = |(cand_rd & wr_union);
    assign waw = |(cand_wr & wr_union);
    assign war = |(cand_wr & rd_union);
    // Unions are empty in IDLE, so only an open batch can see a conflict.
    assign conflict = state == ACCUM && has_req && (raw || waw || war);
    assign timeout = state == ACCUM && timer == TW'(BATCH_TIMEOUT_CYCLES - 1);
    assign accept = !rst && state != FLUSH && has_req && !conflict && !timeout;
    assign full = accept && count == CW'(MAX_BATCH_SIZE - 1);
    assign bus.s_tready = accept ? grant : '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        if (state == FLUSH) state_nx = bus.m_tready ? IDLE : FLUSH;
        else if (full || timeout || conflict) state_nx = FLUSH;
        else if (accept) state_nx = ACCUM;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            count <= '0;
            timer <= '0;
            owner <= '0;
            rd_union <= '0;
            wr_union <= '0;
        end else if (state == FLUSH) begin
            if (bus.m_tready) begin
                count <= '0;
                timer <= '0;
                rd_union <= '0;
                wr_union <= '0;
            end
        end else begin
            if (accept) begin
                rd_union <= rd_union | cand_rd;
                wr_union <= wr_union | cand_wr;
                count <= count + 1'b1;
            end
            if (accept && state == IDLE) owner <= bus.s_owner_id[int'(gidx)*64 +: 64];
            timer <= state == ACCUM ? timer + 1'b1 : '0;
        end
    assign bus.m_tvalid = state == FLUSH;
    assign bus.m_count = count;
    assign bus.m_owner_id = owner;
    assign bus.m_rd_union = rd_union;
    assign bus.m_wr_union = wr_union;
`ifdef BATCH_FORMER_STATS_EN
    logic [STAT_W-1:0] conf_cnt [3];
    logic [STAT_W-1:0] batches;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            conf_cnt <= '{default: '0};
            batches <= '0;
        end else begin
            conf_cnt[CONF_RAW] <= sat_inc(conf_cnt[CONF_RAW], conflict && raw);
            conf_cnt[CONF_WAW] <= sat_inc(conf_cnt[CONF_WAW], conflict && waw);
            conf_cnt[CONF_WAR] <= sat_inc(conf_cnt[CONF_WAR], conflict && war);
            batches <= sat_inc(batches, state == FLUSH && bus.m_tready);
        end
    assign bus.raw_conflicts = conf_cnt[CONF_RAW];
    assign bus.waw_conflicts = conf_cnt[CONF_WAW];
    assign bus.war_conflicts = conf_cnt[CONF_WAR];
    assign bus.batches_emitted = batches;
`else
    assign bus.raw_conflicts = '0;
    assign bus.waw_conflicts = '0;
    assign bus.war_conflicts = '0;
    assign bus.batches_emitted = '0;
`endif
endmodule

// File: doc/batch_former.md
BATCH_FORMER -- requirements
Module: batch_former

Interface
- REQ-001 SHALL have parameter NUM_CH, default 4: number of input transaction channels.
- REQ-002 SHALL have parameter DEP_W, default 256: dependency vector width.
- REQ-003 SHALL have parameter MAX_BATCH_SIZE, default 8: transactions per batch.
- REQ-004 SHALL have parameter BATCH_TIMEOUT_CYCLES, default 100: cycles from first accept to forced close.
- REQ-005 SHALL have port clk, input, 1: single clock for all logic.
- REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
- REQ-007 SHALL have port s_tvalid, input, NUM_CH: per-channel transaction valid.
- REQ-008 SHALL have port s_tready, output, NUM_CH: per-channel accept; at most one bit high per cycle.
- REQ-009 SHALL have port s_owner_id, input, 64*NUM_CH: per-channel owner/program ID; channel i at [64*i +: 64].
- REQ-010 SHALL have ports s_rd_deps and s_wr_deps, input, DEP_W*NUM_CH each: per-channel read and write sets.
- REQ-011 SHALL have port m_tvalid, input m_tready, 1 each: batch descriptor handshake.
- REQ-012 SHALL have ports m_count, output, $clog2(MAX_BATCH_SIZE+1); m_owner_id, output, 64 (first transaction's owner); m_rd_union and m_wr_union, output, DEP_W each.
- REQ-013 SHALL have ports raw_conflicts, waw_conflicts, war_conflicts, batches_emitted, output, 32 each: statistics.

Function
- REQ-014 SHALL implement FSM IDLE (empty batch), ACCUM (1..MAX_BATCH_SIZE-1 held), FLUSH (descriptor presented).
- REQ-015 SHALL grant one valid channel per cycle in IDLE/ACCUM by round-robin; pointer moves to granted+1 mod NUM_CH only on accept.
- REQ-016 SHALL flag conflict for the granted candidate when (wr & union_rd) [WAR], (wr & union_wr) [WAW] or (rd & union_wr) [RAW] is non-zero; overlap of a transaction's own rd and wr sets is not a conflict.
- REQ-017 SHALL accept (s_tready[g]=1) when in IDLE/ACCUM, no conflict, timer below timeout; accept ORs rd/wr into unions and increments count; first accept latches owner ID, starts timer at 0, moves IDLE->ACCUM.
- REQ-018 SHALL enter FLUSH in the accept cycle when count becomes MAX_BATCH_SIZE (MAX_BATCH_SIZE=1 goes IDLE->FLUSH).
- REQ-019 SHALL, on conflict in ACCUM, not accept and enter FLUSH next cycle; the conflicting channel keeps grant priority and is retried first in the new batch.
- REQ-020 SHALL increment timer each ACCUM cycle and enter FLUSH when timer reaches BATCH_TIMEOUT_CYCLES-1; s_tready is low in that cycle (timeout wins over accept).
- REQ-021 SHALL in FLUSH drive m_tvalid=1 with stable descriptor and all s_tready low; on m_tready clear unions, count, timer and return to IDLE (no accept in that cycle).
- REQ-022 SHALL never emit a zero-count descriptor; IDLE never times out.
- REQ-023 SHALL use saturating 32-bit statistics counters; one conflict type counter increments per rejected candidate per type present; batches_emitted increments per m_tvalid&m_tready.

Reset
- REQ-024 SHALL on rst force IDLE, pointer 0, count/timer/unions/owner 0, m_tvalid 0, s_tready 0, all stats 0; reset mid-FLUSH drops the batch.

Configuration
- REQ-025 SHALL with BATCH_FORMER_STATS_EN defined implement REQ-023 counters; undefined, the four statistics outputs are constant 0 and counter logic is absent.

Structure
- REQ-026 SHALL place conflict-type enum (RAW/WAW/WAR), descriptor count-width function and stat width constant in shared package batcher_pkg.
- REQ-027 SHALL instantiate sub-module rr_arbiter (NUM_CH-wide request, one-hot grant, advance input).

Verification
- REQ-028 Eight non-conflicting txns on ch0 (disjoint single bits 0..7 write) -> one descriptor count=8, wr_union=0xFF, owner=first ID.
- REQ-029 ch0 write bit5, then ch1 read bit5 -> descriptor count=1; ch1 starts next batch; raw_conflicts=1.
- REQ-030 One txn, no further input, BATCH_TIMEOUT_CYCLES=100 -> m_tvalid rises 100 cycles after accept, count=1.
- REQ-031 All 4 channels valid continuously, disjoint deps -> grant order 0,1,2,3,0...; each channel accepted twice per 8-batch.
- REQ-032 m_tready held low 20 cycles in FLUSH -> descriptor stable, s_tready all 0; rst asserted mid-FLUSH -> m_tvalid 0 immediately, stats 0.
